// File: rtl/trng_pkg.sv
// Shared types and helpers for the TRNG sampling path.
package trng_pkg;

    // Sampler FSM states.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWarmup  = 3'd1,
        StCollect = 3'd2,
        StHold    = 3'd3,
        StFail    = 3'd4
    } trng_state_e;

    // Width of one delivered random byte.
    localparam int unsigned RAW_W = 8;

    // Bits needed to hold values 0..value-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages clear on the active-high asynchronous reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/trng_sampler.sv
// Samples the ring-oscillator LSB, Von Neumann-debiases it, packs bytes and
// runs a repetition-count health test on the raw stream.
module trng_sampler
    import trng_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV     = 16,
    parameter int unsigned WARMUP_SAMPLES = 32,
    parameter int unsigned REP_LIMIT      = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [7:0]       ro_count,
    output logic             ro_activate,
    output logic [RAW_W-1:0] rnd_byte,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             health_fail,
    output logic             busy
);

    localparam int unsigned DIV_W  = clog2(SAMPLE_DIV);
    localparam int unsigned WARM_W = clog2(WARMUP_SAMPLES);
    localparam int unsigned REP_W  = clog2(REP_LIMIT + 1);
    localparam int unsigned BIT_W  = clog2(RAW_W);

    trng_state_e        state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [WARM_W-1:0]  warm_q, warm_d;
    logic [REP_W-1:0]   rep_q, rep_d, rep_next;
    logic               prev_q, prev_d;
    logic               pair_full_q, pair_full_d;
    logic               pair_bit_q, pair_bit_d;
    logic [RAW_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;

    logic raw_bit;
    logic sampling;
    logic tick;
    logic rep_trip;
    logic byte_done;

    // Only the LSB of the oscillator count carries the entropy we sample.
    logic unused_ro_bits;
    assign unused_ro_bits = ^ro_count[7:1];

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ro_count[0]),
        .q     (raw_bit)
    );

    assign sampling = (state_q == StWarmup) || (state_q == StCollect);
    assign tick     = sampling && (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign rep_next = (raw_bit == prev_q) ? rep_q + REP_W'(1) : REP_W'(1);
    assign rep_trip = tick && (rep_next == REP_W'(REP_LIMIT));

    // Next-state, divider, health, pairing and packing logic.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        warm_d      = warm_q;
        rep_d       = rep_q;
        prev_d      = prev_q;
        pair_full_d = pair_full_q;
        pair_bit_d  = pair_bit_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done   = 1'b0;

        if (sampling) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end else begin
            div_d = '0;
        end

        if (tick) begin
            prev_d = raw_bit;
            rep_d  = rep_next;
        end

        unique case (state_q)
            StIdle: begin
                // Everything restarts cleanly on the next WARMUP entry.
                warm_d      = '0;
                rep_d       = '0;
                prev_d      = 1'b0;
                pair_full_d = 1'b0;
                pair_bit_d  = 1'b0;
                bit_cnt_d   = '0;
                if (run) begin
                    state_d = StWarmup;
                end
            end
            StWarmup: begin
                if (tick) begin
                    warm_d = warm_q + WARM_W'(1);
                    if (rep_trip) begin
                        state_d = StFail;
                    end else if (warm_q == WARM_W'(WARMUP_SAMPLES - 1)) begin
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                if (tick) begin
                    if (!pair_full_q) begin
                        pair_full_d = 1'b1;
                        pair_bit_d  = raw_bit;
                    end else begin
                        pair_full_d = 1'b0;
                        // 01 -> 0, 10 -> 1: the emitted bit is the first of the pair.
                        if (pair_bit_q != raw_bit) begin
                            shift_d   = {shift_q[RAW_W-2:0], pair_bit_q};
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            byte_done = (bit_cnt_q == BIT_W'(RAW_W - 1));
                        end
                    end
                    if (rep_trip) begin
                        state_d = StFail;
                    end else if (byte_done) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (rnd_ready) begin
                    state_d     = StCollect;
                    bit_cnt_d   = '0;
                    pair_full_d = 1'b0;
                end
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Dropping run wins over everything, including a same-cycle handshake.
        if (!run) begin
            state_d = StIdle;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: counters, health state, pair and shift register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            div_q       <= '0;
            warm_q      <= '0;
            rep_q       <= '0;
            prev_q      <= 1'b0;
            pair_full_q <= 1'b0;
            pair_bit_q  <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
        end else begin
            div_q       <= div_d;
            warm_q      <= warm_d;
            rep_q       <= rep_d;
            prev_q      <= prev_d;
            pair_full_q <= pair_full_d;
            pair_bit_q  <= pair_bit_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign ro_activate = (state_q == StWarmup) || (state_q == StCollect) ||
                         (state_q == StHold);
    assign rnd_valid   = (state_q == StHold);
    assign health_fail = (state_q == StFail);
    assign busy        = (state_q != StIdle);
    assign rnd_byte    = shift_q;

endmodule

// File: tb/tb_trng_sampler.sv
// Directed bench for trng_sampler: byte vectors from a table plus
// hand-written warmup, health, abort and reset sequences.
module tb_trng_sampler;

    localparam int unsigned SAMPLE_DIV     = 16;
    localparam int unsigned WARMUP_SAMPLES = 32;
    localparam int unsigned REP_LIMIT      = 24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [7:0] ro_count;
    logic       ro_activate;
    logic [7:0] rnd_byte;
    logic       rnd_valid;
    logic       rnd_ready;
    logic       health_fail;
    logic       busy;

    always #5 clk = ~clk;

    trng_sampler #(
        .SAMPLE_DIV     (SAMPLE_DIV),
        .WARMUP_SAMPLES (WARMUP_SAMPLES),
        .REP_LIMIT      (REP_LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .ro_count    (ro_count),
        .ro_activate (ro_activate),
        .rnd_byte    (rnd_byte),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .health_fail (health_fail),
        .busy        (busy)
    );

    // One byte to collect: raw samples (first sample is the MSB of the
    // len-bit pattern), expected byte and cycles of backpressure in HOLD.
    typedef struct {
        logic [31:0] pat;
        int          len;
        logic [7:0]  exp;
        int          hold;
    } vec_t;

    vec_t vecs[4];
    vec_t abort_vec;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Present one raw sample for a whole sample period (called at posedge+1).
    task automatic drive_sample(input logic b);
        ro_count = {7'($urandom), b};
        repeat (SAMPLE_DIV) @(posedge clk);
        #1;
    endtask

    // Raise run and confirm the oscillator comes on one cycle later.
    task automatic start_run();
        run = 1'b1;
        @(negedge clk);
        check("act_before_edge", {31'd0, ro_activate}, 32'd0);
        @(posedge clk);
        #1;
        check("act_after_run", {30'd0, ro_activate, busy}, 32'd3);
    endtask

    task automatic warmup(input logic first);
        for (int i = 0; i < int'(WARMUP_SAMPLES); i++) begin
            drive_sample(first ^ i[0]);
        end
    endtask

    // Collect one byte, check it under backpressure, then hand it off.
    task automatic apply_vec(input vec_t v, input int idx);
        bit stable;
        for (int i = 0; i < v.len; i++) begin
            if (i == v.len - 1) begin
                check($sformatf("no_early_valid[%0d]", idx), {31'd0, rnd_valid}, 32'd0);
            end
            drive_sample(v.pat[v.len - 1 - i]);
        end
        @(negedge clk);
        check($sformatf("valid[%0d]", idx), {31'd0, rnd_valid}, 32'd1);
        check($sformatf("byte[%0d]", idx), {24'd0, rnd_byte}, {24'd0, v.exp});
        stable = 1'b1;
        for (int c = 0; c < v.hold; c++) begin
            @(negedge clk);
            if (rnd_valid !== 1'b1 || rnd_byte !== v.exp) begin
                stable = 1'b0;
            end
        end
        check($sformatf("hold_stable[%0d]", idx), {31'd0, stable}, 32'd1);
        @(posedge clk);
        #1;
        rnd_ready = 1'b1;
        @(posedge clk);
        #1;
        rnd_ready = 1'b0;
        check($sformatf("valid_drop[%0d]", idx), {29'd0, rnd_valid, busy, ro_activate},
              32'd3);
    endtask

    initial begin
        rst_n     = 1'b1;
        run       = 1'b0;
        rnd_ready = 1'b0;
        ro_count  = 8'h00;

        // pairs 01,10,11,10,00,01,01,10,10,10 -> 0,1,-,1,-,0,0,1,1,1
        vecs[0] = '{32'b01101110000101101010, 20, 8'h67, 200};
        // pairs 10,01,10,01,01,10,01,10
        vecs[1] = '{32'b1001100101100110, 16, 8'hA5, 3};
        // pairs 01,01,11,01,01,00,10,10,10,10
        vecs[2] = '{32'b01011101010010101010, 20, 8'h0F, 3};
        // pairs 10,10,01,01,01,01,10,10
        vecs[3] = '{32'b1010010101011010, 16, 8'hC3, 3};
        // pairs 01,01,10,10,10,10,01,01
        abort_vec = '{32'b0101101010100101, 16, 8'h3C, 2};

        // Reset and idle.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {20'd0, ro_activate, rnd_valid, health_fail, busy, rnd_byte}, 32'd0);
        rst_n = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("idle_outs", {20'd0, ro_activate, rnd_valid, health_fail, busy, rnd_byte}, 32'd0);

        // Warmup, debias/packing and backpressure.
        start_run();
        warmup(1'b0);
        for (int v = 0; v < 4; v++) begin
            apply_vec(vecs[v], v);
        end
        run = 1'b0;
        @(posedge clk);
        #1;
        check("stop_idle", {30'd0, busy, ro_activate}, 32'd0);

        // Health test: warmup ends on 0, then a constant run of ones.
        start_run();
        warmup(1'b1);
        for (int i = 0; i < int'(REP_LIMIT) - 1; i++) begin
            drive_sample(1'b1);
        end
        check("rep_below_limit", {30'd0, health_fail, ro_activate}, 32'd1);
        drive_sample(1'b1);
        check("rep_trip", {28'd0, health_fail, ro_activate, rnd_valid, busy}, 32'b1001);
        repeat (20) @(posedge clk);
        #1;
        check("fail_sticky", {31'd0, health_fail}, 32'd1);
        run = 1'b0;
        @(posedge clk);
        #1;
        check("fail_clear", {30'd0, health_fail, busy}, 32'd0);

        // Abort after 5 emitted bits plus a half pair, then restart.
        start_run();
        warmup(1'b0);
        for (int i = 0; i < 10; i++) begin
            drive_sample(~i[0]);
        end
        drive_sample(1'b1);
        run = 1'b0;
        @(posedge clk);
        #1;
        check("abort_idle", {29'd0, busy, ro_activate, rnd_valid}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        start_run();
        warmup(1'b0);
        apply_vec(abort_vec, 4);

        // Asynchronous reset mid-collection clears outputs without a clock edge.
        drive_sample(1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("async_reset", {20'd0, ro_activate, rnd_valid, health_fail, busy, rnd_byte}, 32'd0);
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trng_sampler.md
Name: trng_sampler

Overview:
- Downstream consumer of the ring-oscillator stage: enables the oscillator and samples the LSB of its 8-bit count output at a fixed divided rate.
- Von Neumann-debiases the raw bits, packs them into bytes and presents each byte on a valid/ready interface to the TRNG output logic.
- Runs a repetition-count health test on raw bits and stops the oscillator on failure.

Parameters:
- SAMPLE_DIV, 16, clk cycles between raw-bit samples (>=4).
- WARMUP_SAMPLES, 32, raw samples discarded after oscillator enable.
- REP_LIMIT, 24, consecutive identical raw bits that trip the health test (>=2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active-high.
- run  input  1  level enable; 1 = generate, 0 = stop and return to IDLE.
- ro_count  input  8  oscillator count output; asynchronous to clk, only bit 0 is used.
- ro_activate  output  1  oscillator enable.
- rnd_byte  output  8  debiased random byte, valid while rnd_valid=1.
- rnd_valid  output  1  byte available.
- rnd_ready  input  1  consumer accepts the byte.
- health_fail  output  1  repetition test tripped; sticky.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: asynchronous, active-high on rst_n; clk is the only clock.
  - All outputs 0; FSM to IDLE; all counters, pair register and shift register cleared.
  - Reset mid-operation aborts immediately; no partial byte survives.
- Synchronization:
  - ro_count[0] passes through a 2-flop synchronizer (reset to 0).
  - The raw bit is the synchronizer output, 2-cycle latency.
- Sample tick:
  - Divider counts 0..SAMPLE_DIV-1, active in WARMUP and COLLECT, otherwise held at 0.
  - tick = (div == SAMPLE_DIV-1); the raw bit is taken on the tick cycle.
- FSM states: IDLE, WARMUP, COLLECT, HOLD, FAIL.
  - IDLE: ro_activate=0. run=1 -> WARMUP.
  - WARMUP: ro_activate=1. Counts WARMUP_SAMPLES ticks, discarding the bits. After the last tick -> COLLECT.
  - COLLECT: ro_activate=1. Pair logic runs on each tick.
    - First bit of a pair is stored.
    - On the second bit: 01 emits 0, 10 emits 1, 00/11 emit nothing. The pair state clears after every second bit.
    - Emitted bits shift left into the shift register; the first emitted bit ends in rnd_byte[7].
    - On the 8th emitted bit -> HOLD.
  - HOLD: rnd_valid=1 and rnd_byte stable. ro_activate stays 1; sampling and health test are paused (divider held).
    - rnd_valid & rnd_ready -> COLLECT next cycle; bit count and pair state cleared.
    - rnd_byte keeps its last value until overwritten.
  - FAIL: health_fail=1, ro_activate=0, rnd_valid=0. Exit only via run=0 -> IDLE, which clears health_fail.
- Run control:
  - run=0 in any state -> IDLE next cycle: ro_activate=0, rnd_valid=0, partial byte discarded.
  - A pending HOLD byte is dropped even if rnd_ready=1 in the same cycle; run has priority.
- Health test (WARMUP and COLLECT):
  - Repetition counter increments on each tick whose raw bit equals the previous raw bit; it resets to 1 on a change.
  - Counter reaching REP_LIMIT -> FAIL next cycle; this overrides a simultaneous 8th emitted bit.
  - The previous-bit register and counter are cleared on entry to WARMUP.
- Handshake:
  - rnd_valid never drops without a handshake, except for run=0, FAIL or reset.
  - A byte is accepted on every cycle where rnd_valid=1 and rnd_ready=1.
  - Minimum byte interval: 16 ticks (8 pairs).
- busy = (state != IDLE).

Decomposition:
- Package trng_pkg:
  - FSM state enum (3-bit: IDLE, WARMUP, COLLECT, HOLD, FAIL).
  - RAW_W=8 byte width constant.
  - Counter width function clog2 used for the divider, warmup and repetition counters.
- Sub-module sync_2ff: a 2-flop synchronizer with async active-high reset, reused for ro_count[0].

Test Plan:
- Reset/idle: rst_n=1, then 0, run=0 for 100 cycles -> all outputs 0, busy=0.
- Warmup timing: run=1 with ro_count[0] toggling every sample -> ro_activate=1 one cycle after run. No pair is consumed before 32 ticks (32*16 clk).
- Debias and packing: drive raw pairs 01,10,11,10,00,01,01,10,10,10 (bench drives a new LSB each tick, accounting for 2-cycle sync latency) -> rnd_byte=8'b01100111, i.e. 0x67, with rnd_valid=1.
- Backpressure: hold rnd_ready=0 for 200 cycles in HOLD -> rnd_byte stable, no new byte. Pulse rnd_ready=1 -> valid drops next cycle and collection resumes.
- Health fail: after warmup, hold ro_count[0]=1 constant -> FAIL after 24 identical ticks: health_fail=1, ro_activate=0. Then run=0 -> health_fail=0, IDLE.
- Abort: run=0 mid-COLLECT after 5 emitted bits, then run=1 -> full warmup repeats and the first byte contains no stale bits.
